// File: rtl/arb_pkg.sv
// Shared definitions for the five-requester round-robin arbiter.
//   N_REQ     : number of requesters (fixed at 5)
//   ID_W      : width of a requester index
//   RESET_PTR : last-owner pointer after reset, so the first search starts at 0
//   state_e   : arbiter FSM states
//   onehot5   : converts a requester index into a one-hot grant vector
package arb_pkg;

    localparam int unsigned N_REQ = 5;
    localparam int unsigned ID_W  = 3;
    localparam logic [ID_W-1:0] RESET_PTR = 3'd4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Index 5..7 does not name a requester and maps to no grant at all.
    function automatic logic [N_REQ-1:0] onehot5(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] oh;
        case (id)
            3'd0:    oh = 5'b00001;
            3'd1:    oh = 5'b00010;
            3'd2:    oh = 5'b00100;
            3'd3:    oh = 5'b01000;
            3'd4:    oh = 5'b10000;
            default: oh = 5'b00000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/rr_arbiter_5_if.sv
// Request/grant bundle between five requesters and the arbiter.
//   req       : request vector, bit i from requester i
//   gnt       : one-hot grant
//   gnt_id    : binary index of the owner, qualified by gnt_valid
//   gnt_valid : any grant active
//   timeout   : one-cycle pulse when a grant was forcibly revoked
// master = requester side, slave = arbiter side.
interface rr_arbiter_5_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_valid;
    logic             timeout;

    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output timeout
    );

endinterface

// File: rtl/rr_pick_5.sv
// Combinational round-robin winner selection for five requesters.
//   req      : request vector
//   last_ptr : index of the previous owner (lowest priority this round)
//   winner   : first requester found searching last_ptr+1, last_ptr+2, ... mod 5
//   any      : at least one request present (winner is meaningful only then)
module rr_pick_5
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_ptr,
    output logic [ID_W-1:0]  winner,
    output logic             any
);

    logic [ID_W-1:0]    start_s;
    logic [2*N_REQ-1:0] dbl_s;
    logic [N_REQ-1:0]   rot_s;
    logic [ID_W-1:0]    off_s;
    logic [ID_W:0]      sum_s;

    // Rotate requests so the search start sits at bit 0, priority-encode, then undo the rotation.
    always_comb begin
        case (last_ptr)
            3'd0:    start_s = 3'd1;
            3'd1:    start_s = 3'd2;
            3'd2:    start_s = 3'd3;
            3'd3:    start_s = 3'd4;
            3'd4:    start_s = 3'd0;
            default: start_s = 3'd0;
        endcase

        // Doubling the vector turns a mod-5 rotate into a plain part-select.
        dbl_s = {req, req};
        rot_s = dbl_s[start_s +: N_REQ];

        casez (rot_s)
            5'b????1: off_s = 3'd0;
            5'b???10: off_s = 3'd1;
            5'b??100: off_s = 3'd2;
            5'b?1000: off_s = 3'd3;
            5'b10000: off_s = 3'd4;
            default:  off_s = 3'd0;
        endcase

        sum_s = {1'b0, start_s} + {1'b0, off_s};
        if (sum_s >= 4'd5) begin
            winner = ID_W'(sum_s - 4'd5);
        end else begin
            winner = sum_s[ID_W-1:0];
        end

        any = |req;
    end

endmodule

// File: rtl/rr_arbiter_5.sv
// Five-requester round-robin arbiter with registered one-hot grant.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   bus      : request/grant bundle (slave side)
// MAX_HOLD bounds the consecutive cycles one owner may keep the grant;
// 0 disables the limit. Every grant is followed by at least one idle cycle.
module rr_arbiter_5
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter_5_if.slave bus
);

    localparam int unsigned CNT_W = (MAX_HOLD <= 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'((MAX_HOLD <= 0) ? 1 : MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_HOLD <= 0) ? 0 : MAX_HOLD - 1);
    localparam logic TIMEOUT_EN = (MAX_HOLD != 0) ? 1'b1 : 1'b0;

    state_e           state_q,     state_d;
    logic [N_REQ-1:0] gnt_q,       gnt_d;
    logic [ID_W-1:0]  gnt_id_q,    gnt_id_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q,   timeout_d;
    logic [ID_W-1:0]  last_ptr_q,  last_ptr_d;
    logic [CNT_W-1:0] hold_cnt_q,  hold_cnt_d;

    logic [ID_W-1:0]  pick_winner_s;
    logic             pick_any_s;
    logic             owner_req_s;

    rr_pick_5 u_pick (
        .req      (bus.req),
        .last_ptr (last_ptr_q),
        .winner   (pick_winner_s),
        .any      (pick_any_s)
    );

    // Owner still requesting; gnt_q is one-hot so a masked OR selects its bit.
    assign owner_req_s = |(bus.req & gnt_q);

    // Next-state and next-output logic for the IDLE/GRANT machine.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        last_ptr_d  = last_ptr_q;
        hold_cnt_d  = hold_cnt_q;

        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    gnt_d       = onehot5(pick_winner_s);
                    gnt_id_d    = pick_winner_s;
                    gnt_valid_d = 1'b1;
                    last_ptr_d  = pick_winner_s;
                    hold_cnt_d  = {CNT_W{1'b0}};
                    state_d     = GRANT;
                end else begin
                    gnt_d       = 5'b00000;
                    gnt_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            GRANT: begin
                if (!owner_req_s) begin
                    gnt_d       = 5'b00000;
                    gnt_valid_d = 1'b0;
                    state_d     = IDLE;
                end else if (TIMEOUT_EN && (hold_cnt_q == CNT_LAST)) begin
                    gnt_d       = 5'b00000;
                    gnt_valid_d = 1'b0;
                    timeout_d   = 1'b1;
                    state_d     = IDLE;
                end else begin
                    // Saturate so an unlimited hold never wraps the counter.
                    if (hold_cnt_q != CNT_SAT) begin
                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    end else begin
                        hold_cnt_d = hold_cnt_q;
                    end
                end
            end
            default: begin
                gnt_d       = 5'b00000;
                gnt_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State, pointer, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= 5'b00000;
            gnt_id_q    <= 3'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            last_ptr_q  <= RESET_PTR;
            hold_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            last_ptr_q  <= last_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_5.sv
// Directed bench for rr_arbiter_5: one instance with MAX_HOLD=16 for the
// ownership/priority scenarios, one with MAX_HOLD=4 for timeout fairness.
module tb_rr_arbiter_5;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    rr_arbiter_5_if if16 ();
    rr_arbiter_5_if if4 ();

    rr_arbiter_5 #(.MAX_HOLD(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16.slave)
    );

    rr_arbiter_5 #(.MAX_HOLD(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4.slave)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [4:0] v);
        if16.req = v;
        if4.req  = v;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [4:0] e_gnt, input logic [2:0] e_id,
                         input logic e_v, input logic e_to);
        chk({tag, "/16.gnt"},       {3'b000, if16.gnt},   {3'b000, e_gnt});
        chk({tag, "/16.gnt_id"},    {5'b00000, if16.gnt_id}, {5'b00000, e_id});
        chk({tag, "/16.gnt_valid"}, {7'b0, if16.gnt_valid}, {7'b0, e_v});
        chk({tag, "/16.timeout"},   {7'b0, if16.timeout},   {7'b0, e_to});
    endtask

    task automatic chk4(input string tag, input logic [4:0] e_gnt, input logic [2:0] e_id,
                        input logic e_v, input logic e_to);
        chk({tag, "/4.gnt"},       {3'b000, if4.gnt},   {3'b000, e_gnt});
        chk({tag, "/4.gnt_id"},    {5'b00000, if4.gnt_id}, {5'b00000, e_id});
        chk({tag, "/4.gnt_valid"}, {7'b0, if4.gnt_valid}, {7'b0, e_v});
        chk({tag, "/4.timeout"},   {7'b0, if4.timeout},   {7'b0, e_to});
    endtask

    // Directed scenario sequence.
    initial begin
        logic [2:0] owners [6];
        logic [4:0] oh;
        errors = 0;
        checks = 0;
        owners = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

        rst_n = 1'b0;
        set_req(5'b00000);
        repeat (3) tick();
        chk16("reset", 5'b00000, 3'd0, 1'b0, 1'b0);
        chk4("reset", 5'b00000, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        tick();
        chk16("idle_noreq", 5'b00000, 3'd0, 1'b0, 1'b0);

        // Single requester 0 held well below the 16-cycle limit.
        set_req(5'b00001);
        tick();
        chk16("t1_grant", 5'b00001, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk16("t1_hold", 5'b00001, 3'd0, 1'b1, 1'b0);
        end
        set_req(5'b00000);
        tick();
        chk16("t1_release", 5'b00000, 3'd0, 1'b0, 1'b0);

        // Fairness with all requesting and a 4-cycle hold limit.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_req(5'b11111);
        for (int g = 0; g < 6; g++) begin
            oh = 5'b00001 << owners[g];
            for (int c = 0; c < 4; c++) begin
                tick();
                chk4("fair_hold", oh, owners[g], 1'b1, 1'b0);
            end
            tick();
            chk4("fair_timeout", 5'b00000, owners[g], 1'b0, 1'b1);
        end
        tick();
        chk4("fair_next", 5'b00010, 3'd1, 1'b1, 1'b0);

        // Asynchronous reset clears outputs without a clock edge.
        rst_n = 1'b0;
        #1;
        chk4("async_rst", 5'b00000, 3'd0, 1'b0, 1'b0);
        chk16("async_rst", 5'b00000, 3'd0, 1'b0, 1'b0);
        set_req(5'b00000);
        tick();
        rst_n = 1'b1;

        // Wrap-around: 4 -> 0 -> 1.
        set_req(5'b10000);
        tick();
        chk16("wrap_g4", 5'b10000, 3'd4, 1'b1, 1'b0);
        set_req(5'b00011);
        tick();
        chk16("wrap_rel4", 5'b00000, 3'd4, 1'b0, 1'b0);
        tick();
        chk16("wrap_g0", 5'b00001, 3'd0, 1'b1, 1'b0);
        set_req(5'b00010);
        tick();
        chk16("wrap_rel0", 5'b00000, 3'd0, 1'b0, 1'b0);
        set_req(5'b00011);
        tick();
        chk16("wrap_g1", 5'b00010, 3'd1, 1'b1, 1'b0);

        // Non-owner request ignored while owner 1 holds.
        set_req(5'b01010);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk16("nonowner_hold", 5'b00010, 3'd1, 1'b1, 1'b0);
        end
        set_req(5'b01000);
        tick();
        chk16("nonowner_rel", 5'b00000, 3'd1, 1'b0, 1'b0);
        tick();
        chk16("nonowner_g3", 5'b01000, 3'd3, 1'b1, 1'b0);

        // Sole requester re-grant after one idle cycle.
        set_req(5'b00100);
        tick();
        chk16("sole_rel3", 5'b00000, 3'd3, 1'b0, 1'b0);
        tick();
        chk16("sole_g2", 5'b00100, 3'd2, 1'b1, 1'b0);
        set_req(5'b00000);
        tick();
        chk16("sole_rel2", 5'b00000, 3'd2, 1'b0, 1'b0);
        set_req(5'b00100);
        tick();
        chk16("sole_regrant", 5'b00100, 3'd2, 1'b1, 1'b0);

        // Reset mid-grant, then search restarts at requester 0.
        set_req(5'b10100);
        rst_n = 1'b0;
        #1;
        chk16("mid_rst", 5'b00000, 3'd0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk16("post_rst", 5'b00100, 3'd2, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
